muldiv_unit: RTL and testbench
==============================

Name: muldiv_unit

Overview:
- Iterative RV32M-style multiply/divide execution unit, parametrised in operand width; sits in EX stage beside the single-cycle ALU.
- Decodes Funct7/Funct3 itself (M-extension encoding); accepts one operation per start/done handshake and returns a WIDTH-bit result.
- Radix-2 shift-add multiply and restoring divide: one bit per cycle; special divide cases take a fast path.
- Pipeline control uses busy to stall; flush aborts an in-flight operation.

Parameters:
- WIDTH, 32, operand/result width in bits; legal values are even and ≥4.
- CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request pulse; sampled only in IDLE
- flush  in  1  synchronous abort of the current operation
- Funct7  in  7  instruction bits 31:25; must be 7'b0000001 for acceptance
- Funct3  in  3  op select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  in  WIDTH  operand rs1; multiplicand/dividend
- SrcB  in  WIDTH  operand rs2; multiplier/divisor
- busy  out  1  high while an operation is in flight (RUN, FIX)
- done  out  1  one-cycle pulse; Result valid in this cycle
- Result  out  WIDTH  result; held until the next done

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, Result=0, counter=0, all datapath registers 0. Reset has priority over flush and start.
- States: IDLE, RUN, FIX.
- IDLE:
  - start=1 and Funct7=0000001 → accept: latch Funct3 and operands.
  - start with any other Funct7 → ignored; no done.
  - start in RUN/FIX → ignored; operands are not re-latched.
- Accept, normal path:
  - Compute |A| and |B| per signedness: MUL/MULH/DIV/REM both signed; MULHSU A signed, B unsigned; MULHU/DIVU/REMU both unsigned.
  - Record sign flags; go to RUN with counter=0.
- Accept, fast path (no RUN). Result is loaded and done=1 in the next cycle; state stays IDLE.
  - Divisor=0: DIV/DIVU → all-ones; REM/REMU → SrcA.
  - Signed overflow (DIV/REM with SrcA=100…0, SrcB=all-ones): DIV → SrcA; REM → 0.
- RUN: one iteration per cycle, counter++; after WIDTH iterations go to FIX.
  - Multiply: 2·WIDTH accumulator, shift-add on the multiplier LSB.
  - Divide: restoring step on a WIDTH+1-bit partial remainder; quotient bit shifted in.
- FIX: apply sign correction.
  - Product negated if sign flags differ.
  - Quotient negated if signs differ; remainder takes the dividend's sign.
  - Select result: MUL low half; MULH/MULHSU/MULHU high half; DIV/DIVU quotient; REM/REMU remainder.
  - Register Result, pulse done=1, return to IDLE.
- Latency: start high in cycle 0 → done high in cycle WIDTH+2 (normal) or cycle 1 (fast path). busy is high cycles 1..WIDTH+1.
- done: exactly one cycle wide; never asserted together with busy. Back-to-back start is legal in the done cycle.
- flush=1 in RUN/FIX → IDLE next cycle; no done; Result unchanged. flush in IDLE cancels a same-cycle start.
- Mid-operation reset: same as flush, but Result is cleared to 0.
- All arithmetic is modulo 2^WIDTH. Negating the most negative value yields itself (required for MULH with 100…0 operands).

Test Plan (WIDTH=32):
- MUL SrcA=7, SrcB=0xFFFFFFFD → Result=0xFFFFFFEB; done in cycle 34; busy high cycles 1..33.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×0x00000002 → 0xFFFFFFFF.
- DIV SrcA=0xFFFFFFF9 (−7), SrcB=2 → 0xFFFFFFFD. REM same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- Fast path: DIVU x/0 → 0xFFFFFFFF, REM 0x1234/0 → 0x1234, DIV 0x80000000/−1 → 0x80000000, REM same → 0; each with done in cycle 1 and busy never high.
- Handshake:
  - start while busy with different operands → ignored; the first result is returned.
  - start in the done cycle → second result done 34 cycles later.
  - start with Funct7=0 → no done.
- flush in cycle 10 of a DIV → busy low in cycle 11, no done, Result keeps its prior value. reset in cycle 10 → Result=0; a subsequent MUL completes normally.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply and restoring
// divide, one bit per cycle, with a single-cycle fast path for divide corner cases.
module muldiv_unit #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             flush,
    input  logic [6:0]       Funct7,
    input  logic [2:0]       Funct3,
    input  logic [WIDTH-1:0] SrcA,
    input  logic [WIDTH-1:0] SrcB,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] Result
);

    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned W2    = 2 * WIDTH;
    localparam int unsigned W1    = WIDTH + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]       state, state_d;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       op;
    logic [WIDTH-1:0] mcand;
    logic [W2-1:0]    acc;
    logic [WIDTH:0]   rem;
    logic             neg_p, neg_r;

    logic             accept, is_div, signed_a, signed_b, sign_a, sign_b;
    logic             div0, ovf, fast;
    logic [WIDTH-1:0] abs_a, abs_b, fast_res;

    // Operand decode, magnitudes and fast-path detection on the raw inputs
    always_comb begin
        accept   = start && !flush && (state == S_IDLE) && (Funct7 == 7'b0000001);
        is_div   = Funct3[2];
        signed_a = is_div ? !Funct3[0] : (Funct3[1:0] != 2'b11);
        signed_b = is_div ? !Funct3[0] : !Funct3[1];
        sign_a   = signed_a && SrcA[WIDTH-1];
        sign_b   = signed_b && SrcB[WIDTH-1];
        abs_a    = sign_a ? WIDTH'(WIDTH'(0) - SrcA) : SrcA;
        abs_b    = sign_b ? WIDTH'(WIDTH'(0) - SrcB) : SrcB;
        div0     = is_div && (SrcB == '0);
        ovf      = is_div && !Funct3[0] && (SrcB == '1)
                   && (SrcA == {1'b1, {(WIDTH-1){1'b0}}});
        fast     = div0 || ovf;
        fast_res = '1;
        if (div0)
            fast_res = Funct3[1] ? SrcA : '1;
        else if (ovf)
            fast_res = Funct3[1] ? '0 : SrcA;
    end

    // Next-state logic
    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (accept && !fast) state_d = S_RUN;
            S_RUN:   if (cnt == CNT_W'(WIDTH - 1)) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (flush)
            state_d = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= S_IDLE;
        else
            state <= state_d;
    end

    logic [WIDTH:0]   mul_sum, rem_sh, rem_nx;
    logic             rem_ge;
    logic [W2-1:0]    prod;
    logic [WIDTH-1:0] quo, rmd, fix_res;

    // One iteration of either algorithm, plus final sign correction
    always_comb begin
        mul_sum = W1'(acc[W2-1:WIDTH]) + (acc[0] ? W1'(mcand) : W1'(0));
        rem_sh  = {rem[WIDTH-1:0], acc[WIDTH-1]};
        rem_ge  = rem_sh >= W1'(mcand);
        rem_nx  = rem_ge ? W1'(rem_sh - W1'(mcand)) : rem_sh;
        prod    = neg_p ? W2'(W2'(0) - acc) : acc;
        quo     = neg_p ? WIDTH'(WIDTH'(0) - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rmd     = neg_r ? WIDTH'(WIDTH'(0) - WIDTH'(rem)) : WIDTH'(rem);
        case (op)
            3'b000:                 fix_res = prod[WIDTH-1:0];
            3'b001, 3'b010, 3'b011: fix_res = prod[W2-1:WIDTH];
            3'b100, 3'b101:         fix_res = quo;
            default:                fix_res = rmd;
        endcase
    end

    // Datapath and registered outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            op     <= '0;
            mcand  <= '0;
            acc    <= '0;
            rem    <= '0;
            neg_p  <= 1'b0;
            neg_r  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            Result <= '0;
        end else begin
            done <= 1'b0;
            busy <= (state_d == S_RUN) || (state_d == S_FIX);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op    <= Funct3;
                        cnt   <= '0;
                        rem   <= '0;
                        mcand <= is_div ? abs_b : abs_a;
                        acc   <= {WIDTH'(0), is_div ? abs_a : abs_b};
                        neg_p <= sign_a ^ sign_b;
                        neg_r <= sign_a;
                        if (fast) begin
                            Result <= fast_res;
                            done   <= 1'b1;
                        end
                    end
                end
                S_RUN: begin
                    cnt <= cnt + CNT_W'(1);
                    if (op[2]) begin
                        rem              <= rem_nx;
                        acc[WIDTH-1:0]   <= {acc[WIDTH-2:0], rem_ge};
                    end else begin
                        acc <= {mul_sum, acc[WIDTH-1:1]};
                    end
                end
                S_FIX: begin
                    if (!flush) begin
                        Result <= fix_res;
                        done   <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed vectors push expected results, a
// negedge monitor pops and checks value and completion cycle on every done.
module tb_muldiv_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          reset, start, flush;
    logic [6:0]    Funct7;
    logic [2:0]    Funct3;
    logic [W-1:0]  SrcA, SrcB;
    logic          busy, done;
    logic [W-1:0]  Result;

    muldiv_unit #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .start(start), .flush(flush),
        .Funct7(Funct7), .Funct3(Funct3), .SrcA(SrcA), .SrcB(SrcB),
        .busy(busy), .done(done), .Result(Result)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0] res;
        int           due;
    } exp_t;

    exp_t         q[$];
    int           n_cmp = 0;
    int           n_err = 0;
    int           ndone = 0;
    logic [W-1:0] last_res = '0;

    function automatic void chk(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, expv, cyc);
        end
    endfunction

    // Monitor: every done is matched against the oldest expectation
    always @(negedge clk) begin
        exp_t e;
        if (done === 1'b1) begin
            ndone++;
            chk("done_busy_exclusive", W'(busy), W'(0));
            if (q.size() == 0) begin
                chk("unexpected_done", W'(done), W'(0));
            end else begin
                e = q.pop_front();
                chk("result", Result, e.res);
                chk("latency", W'(cyc), W'(e.due));
            end
        end else if (q.size() > 0 && cyc > q[0].due) begin
            chk("missing_done", W'(done), W'(1));
            e = q.pop_front();
        end
    end

    // Caller is at posedge+1; start is high for exactly the current cycle
    task automatic issue(input logic [6:0] f7, input logic [2:0] f3,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] res, input int lat,
                         input bit expect_done, output int c0);
        Funct7 = f7; Funct3 = f3; SrcA = a; SrcB = b; start = 1'b1;
        c0 = cyc;
        if (expect_done) begin
            q.push_back('{res, c0 + lat});
            last_res = res;
        end
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_all();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("drain", W'(q.size()), W'(0));
        @(posedge clk); #1;
    endtask

    task automatic watch_busy(input int c0, input bit fast);
        logic expb;
        while (cyc < c0 + W + 3) begin
            @(negedge clk);
            expb = !fast && (cyc - c0) >= 1 && (cyc - c0) <= W + 1;
            chk("busy", W'(busy), W'(expb));
        end
        @(posedge clk); #1;
    endtask

    task automatic run(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res);
        int c0;
        issue(7'b0000001, f3, a, b, res, W + 2, 1'b1, c0);
        wait_all();
    endtask

    task automatic run_fast(input logic [2:0] f3, input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic [W-1:0] res);
        int c0;
        issue(7'b0000001, f3, a, b, res, 1, 1'b1, c0);
        watch_busy(c0, 1'b1);
        wait_all();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0, nd;
        reset = 1'b1; start = 1'b0; flush = 1'b0;
        Funct7 = '0; Funct3 = '0; SrcA = '0; SrcB = '0;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_busy", W'(busy), W'(0));
        chk("reset_done", W'(done), W'(0));
        chk("reset_result", Result, W'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // MUL with latency and busy window
        issue(7'b0000001, 3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, W + 2, 1'b1, c0);
        watch_busy(c0, 1'b0);
        wait_all();

        run(3'b001, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
        run(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        run(3'b010, 32'hFFFF_FFFF, 32'h0000_0002, 32'hFFFF_FFFF);
        run(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        run(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        run(3'b101, 32'd100, 32'd7, 32'd14);
        run(3'b111, 32'd100, 32'd7, 32'd2);

        // Fast path corner cases
        run_fast(3'b101, 32'd5, 32'd0, 32'hFFFF_FFFF);
        run_fast(3'b110, 32'h0000_1234, 32'd0, 32'h0000_1234);
        run_fast(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        run_fast(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000);

        // start while busy must not disturb the in-flight divide
        issue(7'b0000001, 3'b101, 32'd100, 32'd7, 32'd14, W + 2, 1'b1, c0);
        repeat (5) @(posedge clk);
        #1;
        Funct7 = 7'b0000001; Funct3 = 3'b101; SrcA = 32'd1000; SrcB = 32'd3; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_all();

        // Back-to-back start in the done cycle
        issue(7'b0000001, 3'b000, 32'd3, 32'd5, 32'd15, W + 2, 1'b1, c0);
        while (cyc < c0 + W + 2) begin
            @(posedge clk); #1;
        end
        issue(7'b0000001, 3'b111, 32'd100, 32'd7, 32'd2, W + 2, 1'b1, c0);
        wait_all();

        // Illegal Funct7, and flush cancelling a same-cycle start
        nd = ndone;
        issue(7'b0000000, 3'b000, 32'd9, 32'd9, 32'd0, 0, 1'b0, c0);
        flush = 1'b1;
        issue(7'b0000001, 3'b101, 32'd9, 32'd0, 32'd0, 0, 1'b0, c0);
        flush = 1'b0;
        repeat (40) @(posedge clk);
        #1;
        chk("no_done_ignored", W'(ndone - nd), W'(0));
        chk("ignored_busy", W'(busy), W'(0));

        // Flush mid-divide
        nd = ndone;
        issue(7'b0000001, 3'b100, 32'd1000, 32'd3, 32'd0, 0, 1'b0, c0);
        while (cyc < c0 + 10) begin
            @(posedge clk); #1;
        end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(negedge clk);
        chk("flush_busy", W'(busy), W'(0));
        repeat (40) @(posedge clk);
        #1;
        chk("flush_no_done", W'(ndone - nd), W'(0));
        chk("flush_result_held", Result, last_res);

        // Reset mid-divide, then a normal multiply
        nd = ndone;
        issue(7'b0000001, 3'b100, 32'd1000, 32'd3, 32'd0, 0, 1'b0, c0);
        while (cyc < c0 + 10) begin
            @(posedge clk); #1;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        chk("midreset_result", Result, W'(0));
        chk("midreset_busy", W'(busy), W'(0));
        repeat (40) @(posedge clk);
        #1;
        chk("midreset_no_done", W'(ndone - nd), W'(0));
        run(3'b000, 32'd6, 32'd7, 32'd42);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
